register_file: RTL and testbench
================================

# register_file

- Architectural general-purpose register file of the single-cycle CPU.
- Sinks the write-back value selected between memory read data and ALU result, and sources both operand buses for the ALU and the store-data path.
- Storage is 32 registers with one synchronous write port and two combinational read ports; register 0 is hard-wired to zero.
- Sits between the write-back select stage, the instruction decoder (register indices) and the ALU operand inputs.

## Interface

Parameters:
- DATA_W, 32, register width; equals the width of the `DATALENGTH` bus.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of registers (2**ADDR_W).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous active-high reset; clears all registers.
- regWrite  input  1  write enable from the control unit.
- writeReg  input  ADDR_W  destination register index.
- wdData  input  DATA_W  write-back data (memory read data or ALU result, already selected).
- readReg1  input  ADDR_W  index for operand port 1 (rs).
- readReg2  input  ADDR_W  index for operand port 2 (rt).
- readData1  output  DATA_W  contents of readReg1.
- readData2  output  DATA_W  contents of readReg2.

## Operation

- Storage: NUM_REGS x DATA_W flip-flop array, regs[0..31].
- Reset:
  - rst high clears regs[0..31] to 0 immediately, independent of clk.
  - While rst is high, writes are ignored.
  - readData1 and readData2 read 0 during reset and after it until written.
- Write, on the rising edge of clk with rst low:
  - If regWrite == 1 and writeReg != 0: regs[writeReg] <= wdData.
  - If writeReg == 0: the write is discarded and regs[0] stays 0.
  - If regWrite == 0: no state changes.
- Read (combinational):
  - readDataN = (readRegN == 0) ? 0 : regs[readRegN].
  - The behaviour when readRegN equals a same-cycle write target is set under Configuration.
- Both read ports are independent. Both may address the same register and return identical data.
- Full DATA_W write only; there are no byte enables.
- No arithmetic inside the block.

## Timing

- Write latency: data presented in cycle N is visible in regs after edge N+1.
- Read latency: zero cycles, combinational from readReg and the array (plus the bypass path when compiled in).
- Reset deassertion:
  - The first write can occur on the first rising edge after rst falls.
  - rst must be released synchronously to clk by the surrounding reset logic.
- Reset mid-operation: a pending write in the same cycle as rst assertion is lost, and all registers read 0.
- Simultaneous write and read of the same nonzero index: see Configuration.
- Simultaneous write and read of a different index: the read returns the old stored value, unaffected by the write.

## Configuration

Macro: REGFILE_BYPASS_EN.

- Defined (write-through bypass):
  - If regWrite == 1, writeReg != 0 and readRegN == writeReg, then readDataN = wdData in the same cycle.
  - Read-after-write within one cycle therefore sees the new value.
- Undefined:
  - readDataN always reflects stored regs contents.
  - A same-cycle read of the write target returns the old value; the new value appears after the clock edge.
- Register 0 reads 0 in both builds, including when writeReg == 0 and regWrite == 1.

## Test plan

- Reset:
  - Stimulus: assert rst asynchronously mid-cycle after writing regs[5]=0x12345678.
  - Required: readData1 with readReg1=5 drops to 0x00000000 without waiting for a clock edge.
  - Required: after release, a sweep of all 32 indices on both ports returns 0.
- Basic write/read:
  - Stimulus: regWrite=1, writeReg=7, wdData=0xDEADBEEF for one edge.
  - Required: readReg1=7 gives 0xDEADBEEF; readReg2=8 gives 0x00000000.
- Register zero:
  - Stimulus: regWrite=1, writeReg=0, wdData=0xFFFFFFFF.
  - Required: readData1 and readData2 at index 0 stay 0x00000000 before and after the edge.
- Write-enable gating:
  - Stimulus: regs[3]=0x00000011, then regWrite=0, writeReg=3, wdData=0x00000022 for one edge.
  - Required: readData2 at index 3 remains 0x00000011.
- Same-cycle hazard:
  - Stimulus: regs[9]=0xAAAA0000; in one cycle drive regWrite=1, writeReg=9, wdData=0x5555FFFF, readReg1=readReg2=9.
  - Required with REGFILE_BYPASS_EN: both ports return 0x5555FFFF before the edge.
  - Required without the macro: both ports return 0xAAAA0000 before the edge and 0x5555FFFF after it.
- Full sweep:
  - Stimulus: write regs[i] = i*0x01010101 for i=1..31 on consecutive edges, then read pairs (i, 32-i) on both ports.
  - Required: every value matches; index 0 returns 0.

Source files
------------

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Brief    : 32 x DATA_W CPU register file, one synchronous write port, two
//            combinational read ports, register 0 hard-wired to zero.
//            Optional same-cycle write-through bypass: REGFILE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] wdData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2
);

    localparam logic [ADDR_W-1:0] c_ZERO_IDX = '0;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wrEn;

    // Index 0 is never stored, so it stays at its reset value of zero.
    assign w_wrEn = regWrite && (writeReg != c_ZERO_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_regs[writeReg] <= wdData;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Reset must still force zero, so the bypass is qualified by !rst.
    always_comb begin
        readData1 = (readReg1 == c_ZERO_IDX) ? '0 : r_regs[readReg1];
        readData2 = (readReg2 == c_ZERO_IDX) ? '0 : r_regs[readReg2];
        if (w_wrEn && !rst && (readReg1 == writeReg)) begin
            readData1 = wdData;
        end
        if (w_wrEn && !rst && (readReg2 == writeReg)) begin
            readData2 = wdData;
        end
    end
`else
    always_comb begin
        readData1 = (readReg1 == c_ZERO_IDX) ? '0 : r_regs[readReg1];
        readData2 = (readReg2 == c_ZERO_IDX) ? '0 : r_regs[readReg2];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Brief    : Self-checking bench for register_file against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        regWrite = 1'b0;
    logic [4:0]  writeReg = '0;
    logic [31:0] wdData = '0;
    logic [4:0]  readReg1 = '0;
    logic [4:0]  readReg2 = '0;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int nCompared = 0;
    int nMismatched = 0;

    logic [31:0] model [32];

    register_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .regWrite(regWrite), .writeReg(writeReg),
        .wdData(wdData), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (regWrite && writeReg != 5'd0) begin
            model[writeReg] = wdData;
        end
    end

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (idx == 5'd0 || rst) return 32'h0;
        if (BYPASS && regWrite && writeReg == idx) return wdData;
        return model[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare, once per cycle away from the active edge.
    always @(negedge clk) begin
        check("port1", readData1, expRead(readReg1));
        check("port2", readData2, expRead(readReg2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeOne(input logic [4:0] idx, input logic [31:0] val);
        regWrite = 1'b1; writeReg = idx; wdData = val;
        tick();
        regWrite = 1'b0;
    endtask

    initial begin
        tick(); tick();
        #1 check("reset_r1", readData1, 32'h0);
        tick();
        rst = 1'b0;

        // Asynchronous reset drops stored data without a clock edge.
        writeOne(5'd5, 32'h12345678);
        readReg1 = 5'd5;
        #1 check("pre_reset_r5", readData1, 32'h12345678);
        #1 rst = 1'b1;
        #1 check("async_reset_r5", readData1, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i); readReg2 = 5'(31 - i);
            #1 check("reset_sweep_r1", readData1, 32'h0);
            check("reset_sweep_r2", readData2, 32'h0);
            tick();
        end

        writeOne(5'd7, 32'hDEADBEEF);
        readReg1 = 5'd7; readReg2 = 5'd8;
        #1 check("basic_r7", readData1, 32'hDEADBEEF);
        check("basic_r8", readData2, 32'h0);

        readReg1 = 5'd0; readReg2 = 5'd0;
        regWrite = 1'b1; writeReg = 5'd0; wdData = 32'hFFFFFFFF;
        #1 check("zero_pre_r1", readData1, 32'h0);
        check("zero_pre_r2", readData2, 32'h0);
        tick();
        regWrite = 1'b0;
        #1 check("zero_post_r1", readData1, 32'h0);
        check("zero_post_r2", readData2, 32'h0);

        writeOne(5'd3, 32'h00000011);
        writeReg = 5'd3; wdData = 32'h00000022; readReg2 = 5'd3;
        tick();
        #1 check("we_gate_r3", readData2, 32'h00000011);

        writeOne(5'd9, 32'hAAAA0000);
        regWrite = 1'b1; writeReg = 5'd9; wdData = 32'h5555FFFF;
        readReg1 = 5'd9; readReg2 = 5'd9;
        #1 check("hazard_pre_r1", readData1, BYPASS ? 32'h5555FFFF : 32'hAAAA0000);
        check("hazard_pre_r2", readData2, BYPASS ? 32'h5555FFFF : 32'hAAAA0000);
        tick();
        regWrite = 1'b0;
        #1 check("hazard_post_r1", readData1, 32'h5555FFFF);
        check("hazard_post_r2", readData2, 32'h5555FFFF);

        for (int i = 1; i < 32; i++) writeOne(5'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i); readReg2 = 5'(32 - i);
            #1 check("sweep_r1", readData1, 32'(i) * 32'h01010101);
            check("sweep_r2", readData2, 32'((32 - i) % 32) * 32'h01010101);
            tick();
        end

        // Random traffic including occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            regWrite = 1'($urandom_range(0, 1));
            writeReg = 5'($urandom_range(0, 31));
            wdData   = $urandom();
            readReg1 = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
            readReg2 = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) begin
                #1 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        regWrite = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
